video_frame_scheduler: RTL and testbench

Sequences one output frame from the feature-map buffer into the video stream output stage. On a start command it latches the frame geometry and quantisation, pulses the frame-start request, then issues linear reads of packed 3-channel pixels. Reads are throttled by the output stage's almost-full backpressure, and the returned words are forwarded as the video valid/data stream. It sits between the layer controller (start/done) and the video stream output stage.

---
 rtl/video_frame_scheduler_pkg.sv | 44 ++++
 rtl/video_frame_scheduler_valid_delay_line.sv | 43 ++++
 rtl/video_frame_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_video_frame_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_frame_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : video_frame_scheduler_pkg                                      |
// | Purpose  : Shared constants and state encoding for the video frame       |
// |            scheduler and its valid delay line.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package video_frame_scheduler_pkg;

    // Packed pixel: {ch2, ch1, ch0}, each channel 16-bit signed.
    localparam int c_CH_W           = 16;
    localparam int c_PIX_W          = 3 * c_CH_W;
    localparam int c_DIM_W          = 10;
    localparam int c_QUANT_W        = 4;

    // Supported read latency range of the feature buffer.
    localparam int c_MIN_RD_LATENCY = 1;
    localparam int c_MAX_RD_LATENCY = 8;

    // In-flight reads never exceed the read latency, so this must hold
    // c_MAX_RD_LATENCY.
    localparam int c_INFLIGHT_W     = $clog2(c_MAX_RD_LATENCY + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4,
        ST_GAP    = 3'd5
    } state_e;

    // True when (col,row) addresses the final pixel of a col_size x row_size frame.
    function automatic logic is_last_pixel(
        input logic [c_DIM_W-1:0] col,
        input logic [c_DIM_W-1:0] row,
        input logic [c_DIM_W-1:0] col_size,
        input logic [c_DIM_W-1:0] row_size
    );
        return (col == col_size - c_DIM_W'(1)) && (row == row_size - c_DIM_W'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_frame_scheduler_valid_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : valid_delay_line                                              |
// | Purpose  : DEPTH-deep shift register that delays the read strobe so it   |
// |            lines up with the feature-buffer read data.                   |
// | Ports    : clk    - clock                                                |
// |            rst    - synchronous active-high clear of every stage         |
// |            i_din  - bit entering the line                                |
// |            o_dout - i_din delayed by exactly DEPTH cycles                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign sr_d = i_din;
        end else begin : g_multi
            assign sr_d = {sr_q[DEPTH-2:0], i_din};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_dout = sr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : video_frame_scheduler                                         |
// | Purpose  : Streams one frame of packed 3-channel pixels from the feature |
// |            buffer to the video output stage, throttled by the stage's    |
// |            almost-full backpressure.                                     |
// | Ports    : system_clk, rst         - clock, sync active-high reset       |
// |            start, abort            - frame command / early termination   |
// |            cfg_*                   - frame geometry and quantisation     |
// |            mem_rd_en/addr/data     - feature-buffer read port            |
// |            video_output_req        - frame-start pulse to output stage   |
// |            fea_out_quant_size,                                           |
// |            video_col_size          - latched cfg held for the frame      |
// |            video_valid/data/ready  - pixel stream and backpressure       |
// |            busy, frame_done        - status to the layer controller      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module video_frame_scheduler
    import video_frame_scheduler_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 2,    // legal range c_MIN_RD_LATENCY..c_MAX_RD_LATENCY
    parameter int FRAME_GAP  = 4
) (
    input  logic                  system_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [c_DIM_W-1:0]    cfg_col_size,
    input  logic [c_DIM_W-1:0]    cfg_row_size,
    input  logic [c_QUANT_W-1:0]  cfg_quant_size,
    input  logic                  abort,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [c_PIX_W-1:0]    mem_rd_data,
    output logic                  video_output_req,
    output logic [c_QUANT_W-1:0]  fea_out_quant_size,
    output logic [c_DIM_W-1:0]    video_col_size,
    output logic                  video_valid,
    output logic [c_PIX_W-1:0]    video_data,
    input  logic                  video_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    // With no gap configured the frame returns straight to IDLE.
    localparam state_e c_POST_FRAME_ST = (FRAME_GAP == 0) ? ST_IDLE : ST_GAP;

    state_e                 state_q,    state_d;
    logic [ADDR_W-1:0]      addr_q,     addr_d;
    logic [c_DIM_W-1:0]     col_q,      col_d;
    logic [c_DIM_W-1:0]     row_q,      row_d;
    logic [c_DIM_W-1:0]     col_size_q, col_size_d;
    logic [c_DIM_W-1:0]     row_size_q, row_size_d;
    logic [c_QUANT_W-1:0]   quant_q,    quant_d;
    logic                   aborted_q,  aborted_d;
    logic [c_INFLIGHT_W-1:0] inflight_q, inflight_d;
    logic [c_GAP_W-1:0]     gap_q,      gap_d;

    logic rd_en;
    logic req;
    logic done;
    logic valid_dly;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        col_d      = col_q;
        row_d      = row_q;
        col_size_d = col_size_q;
        row_size_d = row_size_q;
        quant_d    = quant_q;
        aborted_d  = aborted_q;
        gap_d      = '0;
        rd_en      = 1'b0;
        req        = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // abort has priority over a coincident start
                if (start && !abort) begin
                    col_size_d = cfg_col_size;
                    row_size_d = cfg_row_size;
                    quant_d    = cfg_quant_size;
                    addr_d     = cfg_base_addr;
                    col_d      = '0;
                    row_d      = '0;
                    aborted_d  = 1'b0;
                    state_d    = ST_REQ;
                end
            end

            ST_REQ: begin
                req = 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    state_d   = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    // Read strobe is gated combinationally by ready so a
                    // low ready stops reads in the very same cycle.
                    rd_en = video_ready;
                    if (rd_en) begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (col_q == col_size_q - c_DIM_W'(1)) begin
                            col_d = '0;
                            row_d = row_q + c_DIM_W'(1);
                        end else begin
                            col_d = col_q + c_DIM_W'(1);
                        end
                        if (is_last_pixel(col_q, row_q, col_size_q, row_size_q)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                // Outstanding reads still complete and are forwarded.
                if (inflight_q == '0) begin
                    state_d = aborted_q ? c_POST_FRAME_ST : ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = c_POST_FRAME_ST;
            end

            ST_GAP: begin
                if (gap_q == c_GAP_W'(FRAME_GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + c_GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outstanding reads: +1 per issued read, -1 per returned word.
    always_comb begin
        inflight_d = inflight_q + c_INFLIGHT_W'(rd_en) - c_INFLIGHT_W'(valid_dly);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            col_size_q <= '0;
            row_size_q <= '0;
            quant_q    <= '0;
            aborted_q  <= 1'b0;
            inflight_q <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            col_size_q <= col_size_d;
            row_size_q <= row_size_d;
            quant_q    <= quant_d;
            aborted_q  <= aborted_d;
            inflight_q <= inflight_d;
            gap_q      <= gap_d;
        end
    end

    // Read strobe delayed to align with returned data; reset flushes it so
    // reads in flight at reset are never forwarded.
    valid_delay_line #(
        .DEPTH (RD_LATENCY)
    ) u_valid_delay_line (
        .clk    (system_clk),
        .rst    (rst),
        .i_din  (rd_en),
        .o_dout (valid_dly)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_rd_en          = rd_en;
    assign mem_rd_addr        = addr_q;
    assign video_output_req   = req;
    assign frame_done         = done;
    assign busy               = (state_q != ST_IDLE);
    assign fea_out_quant_size = quant_q;
    assign video_col_size     = col_size_q;
    assign video_valid        = valid_dly;
    assign video_data         = valid_dly ? mem_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_video_frame_scheduler                                      |
// | Purpose  : Self-checking bench for video_frame_scheduler. Drives frames  |
// |            (directed and random), models the feature buffer, and checks |
// |            the observed read/pixel streams against the frame rules.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_video_frame_scheduler;

    localparam int ADDR_W     = 16;
    localparam int RD_LATENCY = 2;
    localparam int FRAME_GAP  = 4;
    localparam int TIMEOUT    = 3000;

    logic        system_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_base_addr;
    logic [9:0]  cfg_col_size;
    logic [9:0]  cfg_row_size;
    logic [3:0]  cfg_quant_size;
    logic        abort;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [47:0] mem_rd_data;
    logic        video_output_req;
    logic [3:0]  fea_out_quant_size;
    logic [9:0]  video_col_size;
    logic        video_valid;
    logic [47:0] video_data;
    logic        video_ready;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    video_frame_scheduler #(
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (RD_LATENCY),
        .FRAME_GAP  (FRAME_GAP)
    ) dut (
        .system_clk         (system_clk),
        .rst                (rst),
        .start              (start),
        .cfg_base_addr      (cfg_base_addr),
        .cfg_col_size       (cfg_col_size),
        .cfg_row_size       (cfg_row_size),
        .cfg_quant_size     (cfg_quant_size),
        .abort              (abort),
        .mem_rd_en          (mem_rd_en),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_data        (mem_rd_data),
        .video_output_req   (video_output_req),
        .fea_out_quant_size (fea_out_quant_size),
        .video_col_size     (video_col_size),
        .video_valid        (video_valid),
        .video_data         (video_data),
        .video_ready        (video_ready),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    always #5 system_clk = ~system_clk;

    always @(posedge system_clk) cyc <= cyc + 1;

    // Feature-buffer content is a fixed function of the word address.
    function automatic logic [47:0] pix_of(input logic [15:0] a);
        return {a ^ 16'hA5A5, a + 16'h1234, ~a};
    endfunction

    // Feature-buffer model: data for the address read RD_LATENCY cycles ago.
    logic [15:0] mem_pipe [RD_LATENCY];
    always @(posedge system_clk) begin
        for (int i = RD_LATENCY - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
        mem_pipe[0] <= mem_rd_en ? mem_rd_addr : 16'hDEAD;
    end
    assign mem_rd_data = pix_of(mem_pipe[RD_LATENCY-1]);

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge system_clk);
        #1;
    endtask

    // One frame. ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // abort_after >= 1 asserts abort once that many reads have been issued.
    // spam pulses start with scrambled cfg while the block is busy.
    task automatic run_frame(input logic [15:0] base, input int cols, input int rows,
                             input logic [3:0] quant, input int ready_mode,
                             input int abort_after, input bit spam);
        logic [15:0] rd_q[$];
        logic [47:0] vd_q[$];
        int  start_cyc, req_cyc, first_rd, last_rd, last_vld, done_cyc, idle_cyc;
        int  req_cnt, done_cnt, ready_viol, cfg_unstable, n_exp, bad_addr, bad_data;
        bit  aborting, seen_idle;
        logic [9:0] exp_col;
        logic [3:0] exp_quant;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        req_cnt = 0; done_cnt = 0; ready_viol = 0; cfg_unstable = 0;
        req_cyc = -1; first_rd = -1; last_rd = -1; last_vld = -1; done_cyc = -1; idle_cyc = -1;
        aborting = 0; seen_idle = 0;
        exp_col = cols[9:0]; exp_quant = quant;

        step();
        cfg_base_addr  = base;
        cfg_col_size   = cols[9:0];
        cfg_row_size   = rows[9:0];
        cfg_quant_size = quant;
        start          = 1'b1;
        video_ready    = 1'b1;
        start_cyc      = cyc;
        step();
        start = 1'b0;

        for (int t = 0; t < TIMEOUT && !seen_idle; t++) begin
            case (ready_mode)
                0:       video_ready = 1'b1;
                1:       video_ready = pat[t % 4];
                default: video_ready = ($urandom_range(0, 3) != 0);
            endcase
            abort = 1'b0;
            if (abort_after >= 1 && !aborting && rd_q.size() >= abort_after) begin
                abort    = 1'b1;
                aborting = 1;
            end
            start = 1'b0;
            if (spam && busy && ($urandom_range(0, 2) == 0)) begin
                start          = 1'b1;
                cfg_col_size   = 10'($urandom_range(1, 1023));
                cfg_quant_size = 4'($urandom);
                cfg_base_addr  = 16'($urandom);
            end
            @(negedge system_clk);
            if (mem_rd_en) begin
                rd_q.push_back(mem_rd_addr);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (!video_ready) ready_viol++;
            end
            if (video_valid) begin
                vd_q.push_back(video_data);
                last_vld = cyc;
            end
            if (video_output_req) begin
                req_cnt++;
                req_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) begin
                if (video_col_size != exp_col || fea_out_quant_size != exp_quant) cfg_unstable++;
            end else begin
                seen_idle = 1;
                idle_cyc  = cyc;
            end
            step();
        end
        abort = 1'b0;
        start = 1'b0;

        check("frame_terminates", seen_idle, 1);
        n_exp = (abort_after >= 1) ? abort_after : cols * rows;
        check("num_reads", rd_q.size(), n_exp);
        check("num_valid", vd_q.size(), n_exp);
        bad_addr = 0;
        bad_data = 0;
        for (int k = 0; k < rd_q.size(); k++)
            if (rd_q[k] !== 16'(base + 16'(k))) bad_addr++;
        for (int k = 0; k < vd_q.size(); k++)
            if (vd_q[k] !== pix_of(16'(base + 16'(k)))) bad_data++;
        check("addr_sequence_errors", bad_addr, 0);
        check("data_sequence_errors", bad_data, 0);
        check("req_pulses", req_cnt, 1);
        check("req_at_start_plus_1", req_cyc - start_cyc, 1);
        check("first_read_not_before_T2", (first_rd - start_cyc) >= 2, 1);
        check("read_while_not_ready", ready_viol, 0);
        check("cfg_unstable_cycles", cfg_unstable, 0);
        check("last_valid_latency", last_vld - last_rd, RD_LATENCY);
        if (abort_after >= 1) begin
            check("done_pulses_abort", done_cnt, 0);
        end else begin
            check("done_pulses", done_cnt, 1);
            check("done_after_last_valid", (done_cyc - last_vld) >= 1 && (done_cyc - last_vld) <= 3, 1);
            check("gap_to_idle", idle_cyc - done_cyc, FRAME_GAP + 1);
            if (ready_mode == 0) check("full_throughput", last_rd - first_rd, n_exp - 1);
        end
    endtask

    // Reset with reads in flight: outputs clear at once and no stale data returns.
    task automatic reset_mid_frame();
        int n_rd, n_vld;
        bit reached;
        n_rd = 0; n_vld = 0; reached = 0;
        step();
        cfg_base_addr = 16'h4000; cfg_col_size = 10'd16; cfg_row_size = 10'd16;
        cfg_quant_size = 4'd9; start = 1'b1; video_ready = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 50 && !reached; t++) begin
            @(negedge system_clk);
            if (mem_rd_en) n_rd++;
            step();
            if (n_rd >= 2) reached = 1;
        end
        check("reset_reached_reads", reached, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outputs_zero",
              {mem_rd_en, video_valid, busy, video_output_req, frame_done,
               |mem_rd_addr, |video_data, |video_col_size, |fea_out_quant_size}, 0);
        for (int t = 0; t < 12; t++) begin
            @(negedge system_clk);
            if (video_valid || busy || mem_rd_en) n_vld++;
            step();
        end
        check("no_activity_after_reset", n_vld, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; video_ready = 1'b1;
        cfg_base_addr = '0; cfg_col_size = '0; cfg_row_size = '0; cfg_quant_size = '0;
        repeat (3) step();
        check("reset_busy", busy, 0);
        check("reset_strobes", {mem_rd_en, video_valid, video_output_req, frame_done}, 0);
        check("reset_latched_cfg", {video_col_size, fea_out_quant_size}, 0);
        check("reset_addr_data", {mem_rd_addr, video_data}, 0);
        rst = 1'b0;
        step();

        // Abort together with start in IDLE: no frame starts.
        abort = 1'b1; start = 1'b1; cfg_col_size = 10'd4; cfg_row_size = 10'd2;
        step();
        abort = 1'b0; start = 1'b0;
        step();
        check("abort_beats_start", busy, 0);

        run_frame(16'h0100, 4, 2, 4'h5, 0, 0, 0);
        run_frame(16'h0100, 4, 2, 4'h6, 1, 0, 0);
        run_frame(16'h2000, 16, 16, 4'h3, 0, 3, 0);
        run_frame(16'h0300, 5, 3, 4'hA, 2, 0, 1);
        run_frame(16'hFFFE, 4, 1, 4'h1, 0, 0, 0);
        reset_mid_frame();
        run_frame(16'h0100, 4, 2, 4'h7, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            int c, r, ab;
            c  = $urandom_range(1, 8);
            r  = $urandom_range(1, 4);
            ab = 0;
            if (c * r > 1 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, c * r - 1);
            run_frame(16'($urandom), c, r, 4'($urandom), $urandom_range(0, 2), ab,
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
